e_muldiv_unit: RTL and testbench

Execute-stage multiply/divide unit. It owns the architectural HI/LO registers and executes mult, multu, div, divu, mthi and mtlo as a multi-cycle operation with a busy flag. Its HI/LO outputs feed the E→M pipeline register directly. The hazard unit uses its busy output to stall D-stage mult/div/mfhi/mflo instructions.

---
 rtl/e_muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_e_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/e_muldiv_unit.sv
// e_muldiv_unit -- execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. mult/multu/div/divu compute their
// 64-bit result in the issue cycle, hold it in a result latch, and commit it
// to HI/LO after a fixed busy period. mthi/mtlo write HI/LO at the issue edge
// without raising busy. A start seen while busy is ignored.
//
// Ports:
//   clk    in   1   clock, all state changes on the rising edge
//   reset  in   1   synchronous, active-low; clears HI/LO, busy and control
//   start  in   1   E-stage instruction is a mult/div-class operation
//   md_op  in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A      in  32   forwarded rs value
//   B      in  32   forwarded rt value
//   busy   out  1   multi-cycle operation in progress (registered)
//   HI     out 32   architectural HI register
//   LO     out 32   architectural LO register
module e_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        kill;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic        is_mul;
  logic        is_div;
  logic        accept;
  logic [63:0] op_result;

  assign a_s = $signed(A);
  assign b_s = $signed(B);

  // Signed 32x32 product; operands sign-extended to 64 bits before multiply.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Quotient truncates toward zero and the
  // remainder takes the dividend's sign. The one overflowing case
  // (most-negative / -1) is pinned explicitly. A zero divisor yields 0; the
  // result is discarded through kill in that case anyway.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [31:0] q;
    logic signed [31:0] r;
    if (b == 32'sd0) begin
      q = 32'sd0;
      r = 32'sd0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      q = 32'sh8000_0000;
      r = 32'sd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Issue stage: decode and compute the full result in the start cycle.
  always_comb begin
    is_mul    = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    accept    = (state == IDLE) && start && (is_mul || is_div);
    op_result = 64'd0;
    case (md_op)
      OP_MULT:  op_result = mul_signed(a_s, b_s);
      OP_MULTU: op_result = mul_unsigned(A, B);
      OP_DIV:   op_result = div_signed(a_s, b_s);
      OP_DIVU:  op_result = div_unsigned(A, B);
      default:  op_result = 64'd0;
    endcase
  end

  // Result latch: data only, loaded when an operation is accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      res_hi <= op_result[63:32];
      res_lo <= op_result[31:0];
    end
  end

  // Control and architectural registers: IDLE accepts work, RUN counts down
  // and commits the latched result on the edge where cnt is 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      kill  <= 1'b0;
      busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                cnt   <= MULT_CNT;
                kill  <= 1'b0;
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                cnt   <= DIV_CNT;
                kill  <= (B == 32'd0);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            if (!kill) begin
              HI <= res_hi;
              LO <= res_lo;
            end
            cnt   <= 4'd0;
            kill  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= 4'd0;
          kill  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Testbench for e_muldiv_unit: directed scenarios plus randomized operations
// checked against a plain-arithmetic model of HI/LO and busy duration.
module tb_e_muldiv_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  e_muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural model: updates exp_hi/exp_lo and returns the busy length.
  task automatic model(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int ncyc);
    longint sa, sb, q, r;
    logic [63:0] pu, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ncyc = 0;
    case (op)
      3'd1: begin pu = 64'(sa * sb); exp_hi = pu[63:32]; exp_lo = pu[31:0]; ncyc = MC; end
      3'd2: begin pu = ua * ub; exp_hi = pu[63:32]; exp_lo = pu[31:0]; ncyc = MC; end
      3'd3: begin
        ncyc = DC;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          pu = 64'(q); exp_lo = pu[31:0];
          pu = 64'(r); exp_hi = pu[31:0];
        end
      end
      3'd4: begin
        ncyc = DC;
        if (b != 0) begin pu = ua / ub; exp_lo = pu[31:0]; pu = ua % ub; exp_hi = pu[31:0]; end
      end
      3'd5: exp_hi = a;
      3'd6: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issues one op, then waits (bounded) while busy, noting whether HI/LO
  // ever differ from the given pre-operation values during the busy period.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ph, input logic [31:0] pl,
                       output int cycles, output bit stable);
    stable = 1'b1;
    start = 1'b1; md_op = op; A = a; B = b;
    tick;
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (HI !== ph || LO !== pl) stable = 1'b0;
      tick;
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", LO); end
    exp_hi = 32'd0; exp_lo = 32'd0;
    reset = 1'b1;
  endtask

  task automatic test_mult;
    int n, c; bit st; logic [31:0] ph, pl;
    ph = exp_hi; pl = exp_lo;
    model(3'd1, 32'hFFFF_FFFD, 32'd5, n);
    do_op(3'd1, 32'hFFFF_FFFD, 32'd5, ph, pl, c, st);
    n_cmp++; if (c !== n) begin n_err++; $display("FAIL mult_cycles: got %0d want %0d", c, n); end
    n_cmp++; if (!st) begin n_err++; $display("FAIL mult_stable: HI/LO changed during busy"); end
    n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL mult_hi: got %h want %h", HI, exp_hi); end
    n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL mult_lo: got %h want %h", LO, exp_lo); end
  endtask

  task automatic test_multu;
    int n, c; bit st; logic [31:0] ph, pl;
    ph = exp_hi; pl = exp_lo;
    model(3'd2, 32'hFFFF_FFFF, 32'd2, n);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, ph, pl, c, st);
    n_cmp++; if (c !== n) begin n_err++; $display("FAIL multu_cycles: got %0d want %0d", c, n); end
    n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL multu_hi: got %h want %h", HI, exp_hi); end
    n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL multu_lo: got %h want %h", LO, exp_lo); end
  endtask

  task automatic test_div;
    int n, c; bit st; logic [31:0] ph, pl;
    logic [2:0]  ops [3] = '{3'd3, 3'd4, 3'd3};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      ph = exp_hi; pl = exp_lo;
      model(ops[i], as[i], bs[i], n);
      do_op(ops[i], as[i], bs[i], ph, pl, c, st);
      n_cmp++; if (c !== n) begin n_err++; $display("FAIL div%0d_cycles: got %0d want %0d", i, c, n); end
      n_cmp++; if (!st) begin n_err++; $display("FAIL div%0d_stable: HI/LO changed during busy", i); end
      n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL div%0d_hi: got %h want %h", i, HI, exp_hi); end
      n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL div%0d_lo: got %h want %h", i, LO, exp_lo); end
    end
  endtask

  task automatic test_div_zero;
    int n, c; bit st; logic [31:0] ph, pl;
    ph = exp_hi; pl = exp_lo;
    model(3'd5, 32'h1234, 32'd0, n);
    do_op(3'd5, 32'h1234, 32'd0, ph, pl, c, st);
    n_cmp++; if (c !== 0) begin n_err++; $display("FAIL mthi_busy: got %0d cycles want 0", c); end
    n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL mthi_hi: got %h want %h", HI, exp_hi); end
    model(3'd6, 32'h5678, 32'd0, n);
    do_op(3'd6, 32'h5678, 32'd0, ph, pl, c, st);
    n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL mtlo_lo: got %h want %h", LO, exp_lo); end
    ph = exp_hi; pl = exp_lo;
    model(3'd4, 32'd7, 32'd0, n);
    do_op(3'd4, 32'd7, 32'd0, ph, pl, c, st);
    n_cmp++; if (c !== n) begin n_err++; $display("FAIL divz_cycles: got %0d want %0d", c, n); end
    n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL divz_hi: got %h want %h", HI, exp_hi); end
    n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL divz_lo: got %h want %h", LO, exp_lo); end
  endtask

  task automatic test_start_while_busy;
    int n, c;
    model(3'd1, 32'd2, 32'd3, n);
    start = 1'b1; md_op = 3'd1; A = 32'd2; B = 32'd3;
    tick;
    start = 1'b0; md_op = 3'd0;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      if (c == 1) begin start = 1'b1; md_op = 3'd6; A = 32'hDEAD; end
      else if (c == 2) begin start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7; end
      else begin start = 1'b0; md_op = 3'd0; end
      tick;
      c++;
    end
    start = 1'b0; md_op = 3'd0;
    n_cmp++; if (c !== n) begin n_err++; $display("FAIL swb_cycles: got %0d want %0d", c, n); end
    n_cmp++; if (HI !== exp_hi) begin n_err++; $display("FAIL swb_hi: got %h want %h", HI, exp_hi); end
    n_cmp++; if (LO !== exp_lo) begin n_err++; $display("FAIL swb_lo: got %h want %h", LO, exp_lo); end
    tick;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL swb_no_late_start: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit quiet;
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    tick;
    start = 1'b0; md_op = 3'd0;
    repeat (3) tick;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL rstmid_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL rstmid_lo: got %h want 0", LO); end
    quiet = 1'b1;
    repeat (DC + 2) begin
      tick;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) quiet = 1'b0;
    end
    n_cmp++; if (!quiet) begin n_err++; $display("FAIL rstmid_late_write: HI=%h LO=%h busy=%b want 0/0/0", HI, LO, busy); end
  endtask

  task automatic test_back_to_back;
    int n, c; bit st; logic [31:0] ph, pl, a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom | 32'd1;
      ph = exp_hi; pl = exp_lo;
      model((i % 2 == 0) ? 3'd2 : 3'd3, a, b, n);
      do_op((i % 2 == 0) ? 3'd2 : 3'd3, a, b, ph, pl, c, st);
      n_cmp++; if (c !== n) begin n_err++; $display("FAIL b2b%0d_cycles: got %0d want %0d", i, c, n); end
      n_cmp++; if (HI !== exp_hi || LO !== exp_lo)
        begin n_err++; $display("FAIL b2b%0d_hilo: got %h_%h want %h_%h", i, HI, LO, exp_hi, exp_lo); end
    end
  endtask

  task automatic test_random;
    int n, c; bit st; logic [31:0] ph, pl, a, b; logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      ph = exp_hi; pl = exp_lo;
      model(op, a, b, n);
      do_op(op, a, b, ph, pl, c, st);
      n_cmp++; if (c !== n) begin n_err++; $display("FAIL rnd%0d_cycles op%0d: got %0d want %0d", i, op, c, n); end
      n_cmp++; if (!st) begin n_err++; $display("FAIL rnd%0d_stable op%0d: HI/LO changed during busy", i, op); end
      n_cmp++; if (HI !== exp_hi || LO !== exp_lo)
        begin n_err++; $display("FAIL rnd%0d_hilo op%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, HI, LO, exp_hi, exp_lo); end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_div_zero;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
